// File: rtl/sdram_test_pkg.sv
// Shared definitions for the SDRAM pattern tester: FSM state encoding,
// LFSR constants, pattern-select codes and the LFSR step function.
package sdram_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic PAT_INC  = 1'b0;
    localparam logic PAT_LFSR = 1'b1;

    // One step of the right-shifting Galois LFSR (x^16+x^14+x^13+x^11+1).
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR word generator.
// Ports: clk, rst_n (async active-low), load (reseed to LFSR_SEED),
//        advance (step once), q (current word).
module lfsr16
    import sdram_test_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        advance,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       q <= LFSR_SEED;
        else if (load)    q <= LFSR_SEED;
        else if (advance) q <= lfsr_next(q);
    end

endmodule

// File: rtl/sdram_pattern_tester.sv
// Avalon-MM master memory tester: writes a pattern over a word range, reads
// it back with pipelined reads and checks every returned word.
// Ports: clk/rst_n; start, start_addr, length, pattern_sel (test request);
//        busy, done, pass, err_cnt, first_err_addr (status);
//        avalon_sdram_* (master side of the SDRAM controller slave port).
module sdram_pattern_tester
    import sdram_test_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 16,
    parameter int MAX_PENDING = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic              pattern_sel,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W-1:0] avalon_sdram_address,
    output logic [1:0]        avalon_sdram_byteenable_n,
    output logic              avalon_sdram_chipselect,
    output logic [DATA_W-1:0] avalon_sdram_writedata,
    output logic              avalon_sdram_read_n,
    output logic              avalon_sdram_write_n,
    input  logic [DATA_W-1:0] avalon_sdram_readdata,
    input  logic              avalon_sdram_readdatavalid,
    input  logic              avalon_sdram_waitrequest
);

    localparam int OUT_W = $clog2(MAX_PENDING) + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d, len_q, len_d;
    logic [ADDR_W-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, ret_q, ret_d;
    logic [ADDR_W-1:0] fea_q, fea_d, addr_q, addr_d;
    logic              pat_q, pat_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic              cs_q, cs_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
    logic [15:0]       err_q, err_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, exp_word;
    logic [OUT_W-1:0]  out_q, out_d;
    logic [15:0]       gen_word, chk_word;
    logic              gen_load, gen_adv, chk_load, chk_adv;
    logic              wr_acc, rd_acc, rx_ok, rx_dec, can_issue;

    lfsr16 u_gen (.clk(clk), .rst_n(rst_n), .load(gen_load), .advance(gen_adv), .q(gen_word));
    lfsr16 u_chk (.clk(clk), .rst_n(rst_n), .load(chk_load), .advance(chk_adv), .q(chk_word));

    assign wr_acc = cs_q & ~wr_n_q & ~avalon_sdram_waitrequest;
    assign rd_acc = cs_q & ~rd_n_q & ~avalon_sdram_waitrequest;
    // Returns only count while a readback is in flight; stray strobes in
    // other states must not touch the checker or underflow the counter.
    assign rx_ok  = avalon_sdram_readdatavalid & ((state_q == ST_READ) | (state_q == ST_DRAIN));
    assign rx_dec = rx_ok & (out_q != '0);

    always_comb begin
        out_d = out_q;
        if (rd_acc && !rx_dec)      out_d = out_q + OUT_W'(1);
        else if (!rd_acc && rx_dec) out_d = out_q - OUT_W'(1);
    end

    // Issue decision uses next cycle's count so the cap is never exceeded.
    assign can_issue = (out_d < OUT_W'(MAX_PENDING));
    assign exp_word  = (pat_q == PAT_LFSR) ? chk_word : ret_q[15:0];

    always_comb begin
        state_d  = state_q;  base_d   = base_q;   len_d   = len_q;   pat_d  = pat_q;
        wr_idx_d = wr_idx_q; rd_idx_d = rd_idx_q; ret_d   = ret_q;   fea_d  = fea_q;
        addr_d   = addr_q;   wdata_d  = wdata_q;  cs_d    = cs_q;    rd_n_d = rd_n_q;
        wr_n_d   = wr_n_q;   busy_d   = busy_q;   pass_d  = pass_q;  err_d  = err_q;
        done_d   = 1'b0;
        gen_load = 1'b0; gen_adv = 1'b0; chk_load = 1'b0; chk_adv = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d   = start_addr;  len_d    = length;  pat_d = pattern_sel;
                    err_d    = '0;          fea_d    = '0;      pass_d = 1'b0;
                    busy_d   = 1'b1;        gen_load = 1'b1;
                    wr_idx_d = '0;          rd_idx_d = '0;      ret_d = '0;
                    if (length == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WRITE;
                        addr_d  = start_addr;
                        wdata_d = (pattern_sel == PAT_LFSR) ? LFSR_SEED : '0;
                        cs_d    = 1'b1;
                        wr_n_d  = 1'b0;
                    end
                end
            end
            ST_WRITE: begin
                if (wr_acc) begin
                    gen_adv = 1'b1;
                    if (wr_idx_q == len_q - ADDR_W'(1)) begin
                        // Straight into the first read; reseed the checker.
                        state_d  = ST_READ;
                        chk_load = 1'b1;
                        wr_n_d   = 1'b0 | 1'b1;
                        rd_n_d   = 1'b0;
                        addr_d   = base_q;
                    end else begin
                        wr_idx_d = wr_idx_q + ADDR_W'(1);
                        addr_d   = base_q + wr_idx_d;
                        wdata_d  = (pat_q == PAT_LFSR) ? lfsr_next(gen_word) : wr_idx_d[15:0];
                    end
                end
            end
            ST_READ: begin
                if (cs_q && !rd_n_q) begin
                    if (!avalon_sdram_waitrequest) begin
                        rd_idx_d = rd_idx_q + ADDR_W'(1);
                        addr_d   = base_q + rd_idx_d;
                        if (rd_idx_d == len_q) begin
                            state_d = ST_DRAIN;
                            cs_d    = 1'b0;
                            rd_n_d  = 1'b1;
                        end else if (!can_issue) begin
                            cs_d   = 1'b0;
                            rd_n_d = 1'b1;
                        end
                    end
                end else if (can_issue) begin
                    cs_d   = 1'b1;
                    rd_n_d = 1'b0;
                    addr_d = base_q + rd_idx_q;
                end
            end
            ST_DRAIN: begin
                if (out_q == '0) state_d = ST_DONE;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = (err_q == 16'h0000);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Returns arrive in order, so a separate return index names the word.
        if (rx_ok) begin
            chk_adv = 1'b1;
            ret_d   = ret_q + ADDR_W'(1);
            if (avalon_sdram_readdata != exp_word) begin
                if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                if (err_q == 16'h0000) fea_d = base_q + ret_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE; base_q <= '0; len_q <= '0; pat_q <= 1'b0;
            wr_idx_q <= '0; rd_idx_q <= '0; ret_q <= '0; fea_q <= '0;
            addr_q   <= '0; wdata_q <= '0; cs_q <= 1'b0; rd_n_q <= 1'b1; wr_n_q <= 1'b1;
            busy_q   <= 1'b0; done_q <= 1'b0; pass_q <= 1'b0; err_q <= '0; out_q <= '0;
        end else begin
            state_q  <= state_d; base_q <= base_d; len_q <= len_d; pat_q <= pat_d;
            wr_idx_q <= wr_idx_d; rd_idx_q <= rd_idx_d; ret_q <= ret_d; fea_q <= fea_d;
            addr_q   <= addr_d; wdata_q <= wdata_d; cs_q <= cs_d; rd_n_q <= rd_n_d; wr_n_q <= wr_n_d;
            busy_q   <= busy_d; done_q <= done_d; pass_q <= pass_d; err_q <= err_d; out_q <= out_d;
        end
    end

    assign busy                      = busy_q;
    assign done                      = done_q;
    assign pass                      = pass_q;
    assign err_cnt                   = err_q;
    assign first_err_addr            = fea_q;
    assign avalon_sdram_address      = addr_q;
    assign avalon_sdram_byteenable_n = 2'b00;
    assign avalon_sdram_chipselect   = cs_q;
    assign avalon_sdram_writedata    = wdata_q;
    assign avalon_sdram_read_n       = rd_n_q;
    assign avalon_sdram_write_n      = wr_n_q;

endmodule

// File: tb/tb_sdram_pattern_tester.sv
module tb_sdram_pattern_tester;

    localparam int AW = 24;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] length = '0;
    logic          pattern_sel = 1'b0;
    logic          busy, done, pass;
    logic [15:0]   err_cnt;
    logic [AW-1:0] first_err_addr, address;
    logic [1:0]    byteenable_n;
    logic          chipselect, read_n, write_n;
    logic [DW-1:0] writedata;
    logic [DW-1:0] readdata = '0;
    logic          readdatavalid = 1'b0;
    logic          waitrequest = 1'b0;

    always #5 clk = ~clk;

    sdram_pattern_tester dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .length(length), .pattern_sel(pattern_sel), .busy(busy), .done(done),
        .pass(pass), .err_cnt(err_cnt), .first_err_addr(first_err_addr),
        .avalon_sdram_address(address), .avalon_sdram_byteenable_n(byteenable_n),
        .avalon_sdram_chipselect(chipselect), .avalon_sdram_writedata(writedata),
        .avalon_sdram_read_n(read_n), .avalon_sdram_write_n(write_n),
        .avalon_sdram_readdata(readdata), .avalon_sdram_readdatavalid(readdatavalid),
        .avalon_sdram_waitrequest(waitrequest)
    );

    int errors = 0;
    int checks = 0;

    // Slave model configuration and observation logs
    int            lat = 2;
    bit            rand_wait = 1'b0;
    bit            fault_en = 1'b0;
    logic [AW-1:0] fault_addr = '0;
    bit [15:0]     mem [bit [23:0]];
    logic [AW-1:0] wr_a[$];
    logic [15:0]   wr_d[$];
    logic [AW-1:0] rd_a[$];
    logic [15:0]   rq_d[$];
    int            rq_t[$];
    int            cyc = 0, mout = 0, max_out = 0, stall_viol = 0, both_low = 0;
    bit            p_acc = 0, p_rd = 0, p_stall = 0, p_rv = 0;
    logic          p_cs = 0, p_rn = 1, p_wn = 1;
    logic [AW-1:0] p_addr = '0;
    logic [15:0]   p_wd = '0;

    // Avalon slave: everything evaluated on the falling edge, so the
    // transfer accepted at the preceding rising edge is processed here.
    always @(negedge clk) begin : model
        logic [15:0] d;
        if (!rst_n) begin
            rq_d.delete(); rq_t.delete();
            mout = 0; p_acc = 0; p_stall = 0; p_rv = 0;
            readdatavalid = 1'b0; waitrequest = 1'b0;
        end else begin
            if (p_rv) mout--;
            if (p_acc) begin
                if (p_rd) begin
                    d = mem.exists(p_addr) ? mem[p_addr] : 16'h0000;
                    if (fault_en && p_addr == fault_addr) d[0] = ~d[0];
                    rq_d.push_back(d);
                    rq_t.push_back(cyc + lat);
                    rd_a.push_back(p_addr);
                    mout++;
                end else begin
                    mem[p_addr] = p_wd;
                    wr_a.push_back(p_addr);
                    wr_d.push_back(p_wd);
                end
            end
            if (mout > max_out) max_out = mout;
            cyc++;
            if (rq_t.size() > 0 && rq_t[0] <= cyc) begin
                readdatavalid = 1'b1;
                readdata = rq_d.pop_front();
                void'(rq_t.pop_front());
            end else begin
                readdatavalid = 1'b0;
                readdata = 16'h0000;
            end
            p_rv = readdatavalid;
            if (p_stall && (chipselect !== p_cs || read_n !== p_rn || write_n !== p_wn ||
                            address !== p_addr || writedata !== p_wd)) stall_viol++;
            if (!read_n && !write_n) both_low++;
            waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
            p_acc   = chipselect && (!read_n || !write_n) && !waitrequest;
            p_stall = chipselect && (!read_n || !write_n) && waitrequest;
            p_rd = !read_n; p_cs = chipselect; p_rn = read_n; p_wn = write_n;
            p_addr = address; p_wd = writedata;
        end
    end

    task automatic clear_logs();
        wr_a.delete(); wr_d.delete(); rd_a.delete();
        max_out = 0; stall_viol = 0; both_low = 0;
    endtask

    // Pulses start, then waits (bounded) for done; returns at the falling
    // edge where done is seen, with k = falling edges since start was raised.
    task automatic run(input logic [AW-1:0] sa, input logic [AW-1:0] len, input logic ps,
                       input int limit, output bit got, output int k, output logic busy1);
        @(negedge clk);
        start = 1'b1; start_addr = sa; length = len; pattern_sel = ps;
        @(negedge clk);
        start = 1'b0; busy1 = busy; k = 1;
        while (!done && k < limit) begin
            @(negedge clk);
            k++;
        end
        got = done;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin errors++;
            $display("FAIL reset_status: busy=%b done=%b pass=%b want 000", busy, done, pass); end
        checks++; if (err_cnt !== 16'h0 || first_err_addr !== '0) begin errors++;
            $display("FAIL reset_results: err=%h fea=%h want 0 0", err_cnt, first_err_addr); end
        checks++; if (chipselect !== 1'b0 || read_n !== 1'b1 || write_n !== 1'b1 || byteenable_n !== 2'b00) begin errors++;
            $display("FAIL reset_ctrl: cs=%b rn=%b wn=%b be=%b want 0 1 1 00", chipselect, read_n, write_n, byteenable_n); end
        checks++; if (address !== '0 || writedata !== '0) begin errors++;
            $display("FAIL reset_bus: addr=%h wd=%h want 0 0", address, writedata); end
        @(negedge clk); #2 rst_n = 1'b1;
    endtask

    task automatic test_incrementing();
        bit got; int k, bad; logic b1;
        clear_logs(); lat = 2; rand_wait = 0; fault_en = 0;
        run(24'h000000, 24'd16, 1'b0, 2000, got, k, b1);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL inc_done: got=%b want 1 (timeout)", got); end
        checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL inc_busy: busy=%b want 1", b1); end
        checks++; if (pass !== 1'b1 || err_cnt !== 16'h0 || first_err_addr !== '0) begin errors++;
            $display("FAIL inc_result: pass=%b err=%0d fea=%h want 1 0 0", pass, err_cnt, first_err_addr); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL inc_done_pulse: done=%b busy=%b want 0 0", done, busy); end
        bad = 0;
        for (int i = 0; i < wr_a.size(); i++) if (wr_a[i] !== AW'(i) || wr_d[i] !== 16'(i)) bad++;
        checks++; if (wr_a.size() != 16 || bad != 0) begin errors++;
            $display("FAIL inc_writes: count=%0d bad=%0d want 16 0", wr_a.size(), bad); end
        bad = 0;
        for (int i = 0; i < rd_a.size(); i++) if (rd_a[i] !== AW'(i)) bad++;
        checks++; if (rd_a.size() != 16 || bad != 0) begin errors++;
            $display("FAIL inc_reads: count=%0d bad=%0d want 16 0", rd_a.size(), bad); end
    endtask

    task automatic test_lfsr_stall();
        bit got; int k, bad; logic b1; logic [15:0] e;
        clear_logs(); lat = 10; rand_wait = 1; fault_en = 0;
        run(24'h000100, 24'd64, 1'b1, 4000, got, k, b1);
        rand_wait = 0;
        checks++; if (got !== 1'b1 || pass !== 1'b1 || err_cnt !== 16'h0) begin errors++;
            $display("FAIL lfsr_result: done=%b pass=%b err=%0d want 1 1 0", got, pass, err_cnt); end
        repeat (2) @(negedge clk);
        checks++; if (wr_d.size() < 2 || wr_d[0] !== 16'hACE1 || wr_d[1] !== 16'hE270) begin errors++;
            $display("FAIL lfsr_first_words: count=%0d want words ACE1 E270", wr_d.size()); end
        bad = 0; e = 16'hACE1;
        for (int i = 0; i < wr_d.size(); i++) begin
            if (wr_d[i] !== e || wr_a[i] !== AW'(32'h100 + i)) bad++;
            e = (e >> 1) ^ (e[0] ? 16'hB400 : 16'h0000);
        end
        checks++; if (wr_d.size() != 64 || bad != 0) begin errors++;
            $display("FAIL lfsr_writes: count=%0d bad=%0d want 64 0", wr_d.size(), bad); end
        checks++; if (rd_a.size() != 64) begin errors++;
            $display("FAIL lfsr_reads: count=%0d want 64", rd_a.size()); end
        checks++; if (max_out > 8) begin errors++;
            $display("FAIL lfsr_max_pending: max=%0d want <=8", max_out); end
        checks++; if (stall_viol != 0 || both_low != 0) begin errors++;
            $display("FAIL lfsr_stall_stable: changes=%0d both_low=%0d want 0 0", stall_viol, both_low); end
    endtask

    task automatic test_fault();
        bit got; int k; logic b1;
        clear_logs(); lat = 2; rand_wait = 0; fault_en = 1; fault_addr = 24'h000005;
        run(24'h000000, 24'd16, 1'b0, 2000, got, k, b1);
        fault_en = 0;
        checks++; if (got !== 1'b1 || pass !== 1'b0) begin errors++;
            $display("FAIL fault_pass: done=%b pass=%b want 1 0", got, pass); end
        checks++; if (err_cnt !== 16'd1) begin errors++;
            $display("FAIL fault_err_cnt: got=%0d want 1", err_cnt); end
        checks++; if (first_err_addr !== 24'h000005) begin errors++;
            $display("FAIL fault_addr: got=%h want 000005", first_err_addr); end
    endtask

    task automatic test_zero_length();
        bit got; int k; logic b1;
        clear_logs();
        run(24'h000010, 24'd0, 1'b0, 10, got, k, b1);
        checks++; if (got !== 1'b1 || k > 2) begin errors++;
            $display("FAIL zero_done: done=%b cycles=%0d want 1 <=2", got, k); end
        checks++; if (pass !== 1'b1 || err_cnt !== 16'h0) begin errors++;
            $display("FAIL zero_result: pass=%b err=%0d want 1 0", pass, err_cnt); end
        repeat (2) @(negedge clk);
        checks++; if (wr_a.size() + rd_a.size() != 0 || done !== 1'b0) begin errors++;
            $display("FAIL zero_activity: transfers=%0d done=%b want 0 0", wr_a.size() + rd_a.size(), done); end
    endtask

    task automatic test_wrap();
        bit got; int k, bad; logic b1;
        logic [AW-1:0] exp_a [4];
        exp_a[0] = 24'hFFFFFE; exp_a[1] = 24'hFFFFFF; exp_a[2] = 24'h000000; exp_a[3] = 24'h000001;
        clear_logs(); lat = 2;
        run(24'hFFFFFE, 24'd4, 1'b0, 500, got, k, b1);
        checks++; if (got !== 1'b1 || pass !== 1'b1) begin errors++;
            $display("FAIL wrap_pass: done=%b pass=%b want 1 1", got, pass); end
        bad = 0;
        for (int i = 0; i < wr_a.size() && i < 4; i++) if (wr_a[i] !== exp_a[i] || wr_d[i] !== 16'(i)) bad++;
        for (int i = 0; i < rd_a.size() && i < 4; i++) if (rd_a[i] !== exp_a[i]) bad++;
        checks++; if (wr_a.size() != 4 || rd_a.size() != 4 || bad != 0) begin errors++;
            $display("FAIL wrap_addrs: writes=%0d reads=%0d bad=%0d want 4 4 0", wr_a.size(), rd_a.size(), bad); end
    endtask

    task automatic test_back_to_back();
        int k;
        clear_logs(); lat = 2;
        @(negedge clk);
        start = 1'b1; start_addr = 24'h000200; length = 24'd16; pattern_sel = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; start_addr = 24'h000999; length = 24'd3; pattern_sel = 1'b1;
        @(negedge clk);
        start = 1'b0; k = 0;
        while (!done && k < 2000) begin @(negedge clk); k++; end
        checks++; if (done !== 1'b1 || pass !== 1'b1) begin errors++;
            $display("FAIL b2b_done: done=%b pass=%b want 1 1", done, pass); end
        repeat (2) @(negedge clk);
        checks++; if (wr_a.size() != 16 || rd_a.size() != 16 || wr_a[0] !== 24'h000200) begin errors++;
            $display("FAIL b2b_ignored_start: writes=%0d reads=%0d want 16 16 from 000200", wr_a.size(), rd_a.size()); end
    endtask

    task automatic test_reset_mid_read();
        bit got; int k; logic b1;
        clear_logs(); lat = 10;
        @(negedge clk);
        start = 1'b1; start_addr = 24'h000000; length = 24'd64; pattern_sel = 1'b1;
        @(negedge clk);
        start = 1'b0; k = 0;
        while (read_n !== 1'b0 && k < 500) begin @(negedge clk); k++; end
        checks++; if (read_n !== 1'b0) begin errors++; $display("FAIL mid_reach_read: read_n=%b want 0 (timeout)", read_n); end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || err_cnt !== 16'h0 || first_err_addr !== '0) begin errors++;
            $display("FAIL mid_reset_status: busy=%b done=%b pass=%b err=%0d fea=%h want all 0", busy, done, pass, err_cnt, first_err_addr); end
        checks++; if (chipselect !== 1'b0 || read_n !== 1'b1 || write_n !== 1'b1 || address !== '0 || writedata !== '0) begin errors++;
            $display("FAIL mid_reset_bus: cs=%b rn=%b wn=%b addr=%h wd=%h want 0 1 1 0 0", chipselect, read_n, write_n, address, writedata); end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        clear_logs(); lat = 2;
        run(24'h000040, 24'd16, 1'b0, 2000, got, k, b1);
        checks++; if (got !== 1'b1 || pass !== 1'b1 || err_cnt !== 16'h0) begin errors++;
            $display("FAIL mid_rerun: done=%b pass=%b err=%0d want 1 1 0", got, pass, err_cnt); end
    endtask

    initial begin
        test_reset();
        test_incrementing();
        test_lfsr_stall();
        test_fault();
        test_zero_length();
        test_wrap();
        test_back_to_back();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
